// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
// default widths, pipeline depth derivation and add/subtract mode encoding.
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_N_DEF   = 16;
  localparam int CLA_BLK_DEF = 4;

  // Encoding of the `sub` input.
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // One lookahead group is resolved per pipeline stage.
  function automatic int cla_stages(input int n, input int blk);
    return n / blk;
  endfunction

endpackage

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Purely combinational BLK-bit carry-lookahead group.
// Ports:
//   a_i, b_i  : group operand bits
//   cin_i     : carry into the group LSB
//   sum_o     : group sum bits
//   cout_o    : carry out of the group MSB
//   g_o, p_o  : group generate / propagate
//   cmsb_o    : carry into the group MSB (signed overflow of a top group)
// -----------------------------------------------------------------------------
module cla_group
  import cla_pkg::*;
#(
  parameter int BLK = CLA_BLK_DEF
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           cin_i,
  output logic [BLK-1:0] sum_o,
  output logic           cout_o,
  output logic           g_o,
  output logic           p_o,
  output logic           cmsb_o
);

  logic [BLK-1:0] gen_s;
  logic [BLK-1:0] prop_s;
  logic [BLK:0]   carry_s;
  logic           term_s;
  logic           grp_g_s;

  assign gen_s  = a_i & b_i;
  assign prop_s = a_i ^ b_i;

  // Every carry (and the group generate) as a flat sum of products of g/p
  // terms, so no carry depends on a lower-order carry.
  always_comb begin
    carry_s    = {(BLK+1){1'b0}};
    term_s     = 1'b0;
    grp_g_s    = 1'b0;
    carry_s[0] = cin_i;
    for (int i = 0; i < BLK; i++) begin
      term_s = cin_i;
      for (int m = 0; m <= i; m++) begin
        term_s = term_s & prop_s[m];
      end
      carry_s[i+1] = term_s;
      for (int j = 0; j <= i; j++) begin
        term_s = gen_s[j];
        for (int m = j + 1; m <= i; m++) begin
          term_s = term_s & prop_s[m];
        end
        carry_s[i+1] = carry_s[i+1] | term_s;
      end
    end
    for (int j = 0; j < BLK; j++) begin
      term_s = gen_s[j];
      for (int m = j + 1; m < BLK; m++) begin
        term_s = term_s & prop_s[m];
      end
      grp_g_s = grp_g_s | term_s;
    end
  end

  assign sum_o  = prop_s ^ carry_s[BLK-1:0];
  assign cout_o = carry_s[BLK];
  assign g_o    = grp_g_s;
  assign p_o    = &prop_s;
  assign cmsb_o = carry_s[BLK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_cla_addsub
// N-bit pipelined carry-lookahead adder/subtractor, one BLK-bit group resolved
// per stage, bubble-collapsing valid/ready flow control. Latency N/BLK.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready has no path from in_valid)
//   A, B, Cin, sub       : operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid / out_ready: result handshake
//   S, Cout, Ovf, Zero   : registered result and flags
// -----------------------------------------------------------------------------
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int N   = CLA_N_DEF,
  parameter int BLK = CLA_BLK_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         Cout,
  output logic         Ovf,
  output logic         Zero
);

  localparam int STAGES = cla_stages(N, BLK);

  // Stage k word: bits below (k+1)*BLK are the resolved sum, bits above are
  // still operand A. opb_q carries the effective B alongside it.
  logic [N-1:0]      word_q [STAGES];
  logic [N-1:0]      word_d [STAGES];
  logic [N-1:0]      opb_q  [STAGES];
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] valid_q;
  logic              ovf_q;
  logic              zero_q;

  logic [N-1:0]      beff_s;
  logic              ceff_s;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] load_s;
  logic [N-1:0]      src_a_s [STAGES];
  logic [N-1:0]      src_b_s [STAGES];
  logic [STAGES-1:0] src_c_s;
  logic [BLK-1:0]    grp_sum_s [STAGES];
  logic [STAGES-1:0] grp_cout_s;
  logic [STAGES-1:0] grp_g_s;
  logic [STAGES-1:0] grp_p_s;
  logic [STAGES-1:0] grp_cmsb_s;
  logic              unused_s;

  // Operand preparation: subtract is A + ~B + 1 with the carry-in inverted.
  always_comb begin
    beff_s = (sub == MODE_ADD) ? B : ~B;
    ceff_s = Cin ^ (sub == MODE_SUB);
  end

  // Bubble-collapsing advance chain, evaluated from the output back.
  always_comb begin
    adv_s             = {STAGES{1'b0}};
    load_s            = {STAGES{1'b0}};
    adv_s[STAGES-1]   = !valid_q[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_s[k] = !valid_q[k] || adv_s[k+1];
    end
    in_ready  = adv_s[0] && !rst;
    load_s[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load_s[k] = adv_s[k] && valid_q[k-1];
    end
  end

  // Each group takes its operands and carry from the previous stage register.
  always_comb begin
    src_a_s[0] = A;
    src_b_s[0] = beff_s;
    src_c_s    = {STAGES{1'b0}};
    src_c_s[0] = ceff_s;
    for (int k = 1; k < STAGES; k++) begin
      src_a_s[k] = word_q[k-1];
      src_b_s[k] = opb_q[k-1];
      src_c_s[k] = carry_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_grp
    cla_group #(.BLK(BLK)) u_grp (
      .a_i    (src_a_s[k][k*BLK +: BLK]),
      .b_i    (src_b_s[k][k*BLK +: BLK]),
      .cin_i  (src_c_s[k]),
      .sum_o  (grp_sum_s[k]),
      .cout_o (grp_cout_s[k]),
      .g_o    (grp_g_s[k]),
      .p_o    (grp_p_s[k]),
      .cmsb_o (grp_cmsb_s[k])
    );
  end

  // Splice the freshly resolved group into the stage word.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      word_d[k]                = src_a_s[k];
      word_d[k][k*BLK +: BLK]  = grp_sum_s[k];
    end
  end

  // Group G/P are not needed once the carry-out is available per group.
  assign unused_s = ^{grp_g_s, grp_p_s, grp_cmsb_s};

  // Pipeline registers; the last stage doubles as the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {STAGES{1'b0}};
      carry_q <= {STAGES{1'b0}};
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= {N{1'b0}};
        opb_q[k]  <= {N{1'b0}};
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_s[k]) begin
          valid_q[k] <= load_s[k];
        end
        if (load_s[k]) begin
          word_q[k]  <= word_d[k];
          opb_q[k]   <= src_b_s[k];
          carry_q[k] <= grp_cout_s[k];
        end
      end
      if (load_s[STAGES-1]) begin
        ovf_q  <= grp_cout_s[STAGES-1] ^ grp_cmsb_s[STAGES-1];
        zero_q <= (word_d[STAGES-1] == {N{1'b0}});
      end
    end
  end

  assign out_valid = valid_q[STAGES-1];
  assign S         = word_q[STAGES-1];
  assign Cout      = carry_q[STAGES-1];
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
module tb_pipelined_cla_addsub;

  localparam int N   = 16;
  localparam int BLK = 4;
  localparam int LAT = 4;
  localparam longint TWO_N = longint'(1) << N;
  localparam longint MAXS  = (longint'(1) << (N - 1)) - 1;
  localparam longint MINS  = -(longint'(1) << (N - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         Cout;
  logic         Ovf;
  logic         Zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_out = 0;
  bit lat_chk = 1'b1;

  typedef struct {
    logic [N-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    int           acc;
  } exp_t;

  exp_t q[$];

  pipelined_cla_addsub #(.N(N), .BLK(BLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .Ovf       (Ovf),
    .Zero      (Zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic c, input logic s);
    longint ua, ub, sa, sb, cc, u, sv;
    logic [63:0] uv;
    exp_t r;
    ua = longint'(a);
    ub = longint'(b);
    cc = c ? 64'sd1 : 64'sd0;
    sa = a[N-1] ? ua - TWO_N : ua;
    sb = b[N-1] ? ub - TWO_N : ub;
    if (s) begin
      u    = ua - ub - cc;
      sv   = sa - sb - cc;
      r.co = (ua >= ub + cc);
    end else begin
      u    = ua + ub + cc;
      sv   = sa + sb + cc;
      r.co = (u >= TWO_N);
    end
    uv    = u;
    r.s   = uv[N-1:0];
    r.ov  = (sv > MAXS) || (sv < MINS);
    r.z   = (r.s == '0);
    r.acc = 0;
    return r;
  endfunction

  // Scoreboard: every output transfer is checked against the oldest accepted beat.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", {31'd0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_S", {16'd0, S}, {16'd0, e.s});
          chk("sb_Cout", {31'd0, Cout}, {31'd0, e.co});
          chk("sb_Ovf", {31'd0, Ovf}, {31'd0, e.ov});
          chk("sb_Zero", {31'd0, Zero}, {31'd0, e.z});
          if (lat_chk) chk("sb_latency", cyc - e.acc, LAT);
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        e     = model(A, B, Cin, sub);
        e.acc = cyc;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic s);
    bit acc;
    int tries;
    A = a; B = b; Cin = c; sub = s; in_valid = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_check(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic c, input logic s, input logic [N-1:0] es,
                            input logic eco, input logic eov, input logic ez);
    exp_t m;
    bit found;
    m = model(a, b, c, s);
    chk({name, "_model"}, {13'd0, m.s, m.co, m.ov, m.z}, {13'd0, es, eco, eov, ez});
    drive(a, b, c, s);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    chk({name, "_seen"}, {31'd0, found}, 32'd1);
    chk({name, "_S"}, {16'd0, S}, {16'd0, es});
    chk({name, "_flags"}, {29'd0, Cout, Ovf, Zero}, {29'd0, eco, eov, ez});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n0;
    int idx;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_S", {16'd0, S}, 32'd0);
    chk("rst_flags", {29'd0, Cout, Ovf, Zero}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Directed add / flag / subtract vectors
    send_check("add_small", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    send_check("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_check("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send_check("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send_check("sub_brw",   16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
    send_check("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    send_check("add_cin",   16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    // Back-to-back stream, no backpressure
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      drive(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("stream_count", n_out - n0, 8);
    chk("stream_drained", q.size(), 0);

    // Backpressure: out_ready low for cycles 3..10 of the stream
    lat_chk = 1'b0;
    n0 = n_out;
    idx = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      out_ready = !(c >= 3 && c <= 10);
      in_valid  = 1'b1;
      A   = 16'(32'h1111 * idx + 32'h00F0);
      B   = 16'(32'h0F0F ^ idx);
      sub = idx[0];
      Cin = idx[1];
      @(negedge clk);
      if (c <= 11) chk("bp_in_ready", {31'd0, in_ready}, {31'd0, (c <= 3 || c >= 11)});
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (LAT + 3) @(posedge clk);
    #1;
    chk("bp_count", n_out - n0, 8);
    chk("bp_drained", q.size(), 0);
    lat_chk = 1'b1;

    // Reset with three beats in flight
    drive(16'h0101, 16'h0202, 1'b0, 1'b0);
    drive(16'h0303, 16'h0404, 1'b0, 1'b0);
    drive(16'h0505, 16'h0606, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = n_out;
    A = 16'h1234; B = 16'h0F0F; Cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_S", {16'd0, S}, 32'd0);
    chk("midrst_flags", {29'd0, Cout, Ovf, Zero}, 32'd0);
    chk("midrst_in_ready_after", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("midrst_count", n_out - n0, 1);
    chk("midrst_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_cla_addsub.md
Name: pipelined_cla_addsub

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. Generalises the 4-bit combinational CLA to N bits, split into BLK-bit lookahead groups with one group per pipeline stage. Adds subtract mode, status flags and valid/ready handshakes on input and output. It sits in the datapath library as the standard wide adder for streaming arithmetic units.

Parameters:
N, 16, operand and result width; must be a multiple of BLK and at least BLK.
BLK, 4, CLA group width; each stage resolves one group.
STAGES, N/BLK, derived localparam, never overridden; this is the pipeline depth and the latency.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operand beat present.
in_ready  out  1  block can accept a beat this cycle.
A  in  N  operand A, unsigned or two's complement.
B  in  N  operand B.
Cin  in  1  carry-in in add mode; borrow-in in sub mode.
sub  in  1  0 = add, 1 = subtract.
out_valid  out  1  result beat present.
out_ready  in  1  consumer accepts the result.
S  out  N  sum or difference.
Cout  out  1  carry-out; in sub mode 1 = no borrow.
Ovf  out  1  signed overflow.
Zero  out  1  S equals 0.

Behaviour:
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- Operand preparation at capture: Beff = sub ? ~B : B; ceff = Cin ^ sub.
  - sub=1, Cin=0 gives A-B.
  - sub=1, Cin=1 gives A-B-1.
- Stage k (k = 0..STAGES-1) holds a valid bit, carry c[k], the partial sum of the low k*BLK bits, and the unresolved upper operand bits.
- Each stage computes group k with a BLK-bit lookahead: generate = a&b, propagate = a^b, carries from the group G/P terms, no ripple. Group k uses the carry registered by stage k-1 (ceff for stage 0).
- Latency: a beat accepted on edge t produces out_valid on edge t+STAGES, given no stalls. Throughput is one beat per cycle.
- The last stage is the output register; S, Cout, Ovf and Zero are registered outputs.
- Flag definitions:
  - Cout = carry out of bit N-1.
  - Ovf = carry into bit N-1 XOR carry out of bit N-1.
  - Zero = (S == 0).
- Flow control is bubble-collapsing:
  - The last stage advances when !out_valid || out_ready.
  - Stage k advances when it is empty or stage k+1 advances.
  - in_ready = stage 0 advances; it is combinational from stage valids and out_ready, with no path from in_valid.
- Stalled stages hold all contents unchanged. Up to STAGES beats can be in flight. Order is preserved; beats are never dropped or duplicated.
- Simultaneous accept and emit when full (out_ready=1): the pipeline shifts and the new beat is accepted in the same cycle.
- Operand changes while in_ready=0 are ignored.
- Reset:
  - All stage valids, out_valid, S, Cout, Ovf and Zero go to 0.
  - in_ready=0 while rst=1; in_ready=1 on the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight beats; no result from before reset ever appears.
- N=BLK degenerates to a single registered CLA with latency 1.

Decomposition:
- Shared package cla_pkg:
  - default N and BLK;
  - STAGES derivation;
  - sub-mode encoding constants (MODE_ADD=0, MODE_SUB=1).
- One sub-module, cla_group: purely combinational BLK-bit lookahead.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, group G/P, and the carry into the MSB (used for Ovf in the top group).
  - It is instantiated STAGES times, once per stage.

Test Plan (N=16, BLK=4, latency 4):
1. A=0x0001, B=0x0002, Cin=0, sub=0, out_ready=1 -> 4 cycles later S=0x0003, Cout=0, Ovf=0, Zero=0.
2. A=0xFFFF, B=0x0001, Cin=0, sub=0 -> S=0x0000, Cout=1, Zero=1, Ovf=0. Then A=0x7FFF, B=0x0001 -> S=0x8000, Ovf=1, Cout=0.
3. Subtract: A=0x0005, B=0x0007, sub=1, Cin=0 -> S=0xFFFE, Cout=0, Ovf=0. Then A=0x0007, B=0x0005, sub=1, Cin=1 -> S=0x0001, Cout=1.
4. Back-to-back stream of 8 random beats with out_ready=1 -> one result per cycle after a 4-cycle fill, in order, each matching the reference model A±B±carry.
5. Backpressure: stream 8 beats with out_ready=0 for cycles 3-10:
   - pipeline fills and in_ready falls after 4 beats are held;
   - in_ready rises in the same cycle out_ready returns;
   - all 8 results appear exactly once, in order.
6. Assert rst for 1 cycle while 3 beats are in flight -> next cycle out_valid=0, S=0, all flags=0. Then in_ready=1, the first post-reset beat emerges 4 cycles after its acceptance, and no stale beat is ever emitted.
